// File: rtl/i2s_tx_sample_buffer.sv
// i2s_tx_sample_buffer
// Elastic FIFO between the DSP output and the I2S transmitter. Samples are
// pushed on the DSP packet-changed strobe. One sample is popped per stereo
// frame, on each falling edge of ws. The buffer primes to half-full before
// playback starts. Sticky flags report underflow and overflow.
//
// Optional build macro:
//   TXBUF_MUTE_ON_UNDERFLOW_EN - when defined, txSample_o is forced to zero on an
//   underflow and stays zero while re-priming. When undefined, txSample_o holds
//   the last played sample.
module i2s_tx_sample_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       sclk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           i2sTxPkt_i,
    input  logic                       i2sTxPktChanged_i,
    input  logic                       ws_i,
    output logic [WIDTH-1:0]           txSample_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       playing_o,
    output logic                       underflow_o,
    output logic                       overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] HALF_LVL = LVL_W'(DEPTH / 2);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] tx_sample_q, tx_sample_d;
    logic             underflow_q, underflow_d;
    logic             overflow_q, overflow_d;
    logic             ws_q, ws_d;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic pop_evt;
    logic empty;
    logic full;
    logic pop_ok;
    logic push_ok;
    logic pop_underflow;

    // Decode the events for this cycle: the ws falling edge, and which of push and pop actually take effect.
    always_comb begin
        pop_evt       = ws_q & ~ws_i;
        empty         = (level_q == '0);
        full          = (level_q == FULL_LVL);
        pop_ok        = (state_q == RUN) && pop_evt && !empty;
        pop_underflow = (state_q == RUN) && pop_evt && empty;
        // A pop in the same cycle frees a slot, so a push into a full buffer is still accepted.
        push_ok       = i2sTxPktChanged_i && (!full || pop_ok);
    end

    // Compute the next value of the pointers, level, output sample, flags and state.
    always_comb begin
        // NOTE: give every always_comb output a default before any branch; a path that skips an assignment infers a latch.
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        tx_sample_d = tx_sample_q;
        underflow_d = underflow_q;
        overflow_d  = overflow_q;
        ws_d        = ws_i;

        // DEPTH is a power of two, so the pointers wrap without extra logic.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (i2sTxPktChanged_i && !push_ok) begin
            overflow_d = 1'b1;
        end

        if (pop_ok) begin
            tx_sample_d = mem_q[rd_ptr_q];
            rd_ptr_d    = rd_ptr_q + 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        case (state_q)
            FILL: begin
                // The decision uses the registered level, so RUN starts one cycle after half-full is reached.
                if (level_q >= HALF_LVL) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (pop_underflow) begin
                    underflow_d = 1'b1;
                    state_d     = FILL;
`ifdef TXBUF_MUTE_ON_UNDERFLOW_EN
                    tx_sample_d = '0;
`endif
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Register the control state. A synchronous reset discards all buffered data.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            tx_sample_q <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            ws_q        <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            tx_sample_q <= tx_sample_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            ws_q        <= ws_d;
        end
    end

    // Write the sample storage on each accepted push.
    always_ff @(posedge sclk) begin
        // NOTE: the storage array has no reset. The pointers and level decide which entries are valid, so stale contents are never read.
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i2sTxPkt_i;
        end
    end

    assign txSample_o  = tx_sample_q;
    assign level_o     = level_q;
    assign playing_o   = (state_q == RUN);
    assign underflow_o = underflow_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_i2s_tx_sample_buffer.sv
// Directed bench for i2s_tx_sample_buffer. Each accepted push appends its
// sample to a scoreboard queue. Each serviced ws fall pops the queue, and the
// popped value is compared with txSample_o.
module tb_i2s_tx_sample_buffer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic             sclk = 1'b0;
    logic             rst  = 1'b1;
    logic [WIDTH-1:0] pkt  = '0;
    logic             chg  = 1'b0;
    logic             ws   = 1'b0;
    logic [WIDTH-1:0] tx_sample;
    logic [3:0]       level;
    logic             playing;
    logic             underflow;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_tx;

    i2s_tx_sample_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .sclk              (sclk),
        .rst               (rst),
        .i2sTxPkt_i        (pkt),
        .i2sTxPktChanged_i (chg),
        .ws_i              (ws),
        .txSample_o        (tx_sample),
        .level_o           (level),
        .playing_o         (playing),
        .underflow_o       (underflow),
        .overflow_o        (overflow)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle push strobe. Control returns at the next negedge, after the push has registered.
    task automatic push(input logic [WIDTH-1:0] d, input bool_accept);
        pkt = d;
        chg = 1'b1;
        if (bool_accept) exp_q.push_back(d);
        @(negedge sclk);
        chg = 1'b0;
    endtask

    // Drive one stereo frame: ws high for 8 cycles, then low for 8 cycles. The fall comes at the start of the low half.
    task automatic frame(input string tag, input bit expect_pop);
        ws = 1'b1;
        repeat (8) @(negedge sclk);
        ws = 1'b0;
        repeat (8) @(negedge sclk);
        if (expect_pop) begin
            if (exp_q.size() == 0) begin
                check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
            end else begin
                m_tx = exp_q.pop_front();
            end
        end
        check({tag, "_tx"}, 32'(tx_sample), 32'(m_tx));
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        repeat (10) @(negedge sclk);
        rst = 1'b0;
        m_tx = '0;
        check("rst_tx", 32'(tx_sample), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_playing", 32'(playing), 32'd0);
        check("rst_flags", 32'({underflow, overflow}), 32'd0);

        // Prime with four samples. Playback starts one cycle after half-full.
        for (int i = 1; i <= 4; i++) push(16'(i), 1'b1);
        check("prime_level", 32'(level), 32'd4);
        check("prime_lag", 32'(playing), 32'd0);
        @(negedge sclk);
        check("prime_playing", 32'(playing), 32'd1);
        check("prime_tx_hold", 32'(tx_sample), 32'd0);
        for (int i = 0; i < 4; i++) frame("prime_pop", 1'b1);
        check("drain_level", 32'(level), 32'd0);

        // Underflow: a ws fall in RUN while the buffer is empty.
`ifdef TXBUF_MUTE_ON_UNDERFLOW_EN
        m_tx = '0;
`endif
        frame("uflow", 1'b0);
        check("uflow_flag", 32'(underflow), 32'd1);
        check("uflow_playing", 32'(playing), 32'd0);

        // Overflow: nine pushes and no ws edges. The ninth push is dropped.
        for (int i = 0; i < 9; i++) push(16'hA000 + 16'(i), i < DEPTH);
        check("oflow_level", 32'(level), 32'd8);
        check("oflow_flag", 32'(overflow), 32'd1);
        @(negedge sclk);
        check("oflow_playing", 32'(playing), 32'd1);
        for (int i = 0; i < DEPTH; i++) frame("oflow_pop", 1'b1);
        check("oflow_drain_level", 32'(level), 32'd0);

        // Simultaneous push and pop while full.
        rst = 1'b1;
        @(negedge sclk);
        rst = 1'b0;
        m_tx = '0;
        for (int i = 0; i < DEPTH; i++) push(16'hC000 + 16'(i), 1'b1);
        @(negedge sclk);
        check("simul_pre_level", 32'(level), 32'd8);
        check("simul_pre_playing", 32'(playing), 32'd1);
        ws = 1'b1;
        repeat (8) @(negedge sclk);
        ws  = 1'b0;
        m_tx = exp_q.pop_front();
        push(16'hBEEF, 1'b1);
        check("simul_level", 32'(level), 32'd8);
        check("simul_oflow", 32'(overflow), 32'd0);
        check("simul_tx", 32'(tx_sample), 32'(m_tx));
        repeat (7) @(negedge sclk);
        for (int i = 0; i < DEPTH; i++) frame("simul_pop", 1'b1);
        check("simul_last", 32'(m_tx), 32'hBEEF);
        check("simul_drain_level", 32'(level), 32'd0);
`ifdef TXBUF_MUTE_ON_UNDERFLOW_EN
        m_tx = '0;
`endif
        frame("simul_uflow", 1'b0);
        check("simul_uflow_flag", 32'(underflow), 32'd1);

        // Mid-run reset with five entries buffered.
        for (int i = 0; i < 6; i++) push(16'hD000 + 16'(i), 1'b1);
        @(negedge sclk);
        check("mid_pre_playing", 32'(playing), 32'd1);
        frame("mid_pop", 1'b1);
        check("mid_pre_level", 32'(level), 32'd5);
        rst = 1'b1;
        @(negedge sclk);
        rst = 1'b0;
        exp_q.delete();
        m_tx = '0;
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_playing", 32'(playing), 32'd0);
        check("mid_rst_tx", 32'(tx_sample), 32'd0);
        check("mid_rst_flags", 32'({underflow, overflow}), 32'd0);
        frame("mid_after", 1'b0);
        check("mid_after_level", 32'(level), 32'd0);
        check("mid_after_flags", 32'({underflow, overflow}), 32'd0);
        check("mid_after_playing", 32'(playing), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
